// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter
//
// Shares one AXI3 master port between the instruction-fetch and the
// data-memory sram-like request interfaces of the pipeline.
//
// Handshake contract (all channels):
//   * sram side: the requester raises req with a stable payload and holds
//     it until addr_ok is seen high in the same cycle. addr_ok is
//     combinational. data_ok pulses for exactly one cycle per accepted
//     request, carrying rdata for reads.
//   * AXI side: a transfer happens on the rising clk edge where valid and
//     ready are both high. Once raised, valid and its payload stay stable
//     until that edge. rready and bready are tied high.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   inst_sram_*           instruction request side (reads only; wr, wstrb
//                         and wdata are ignored)
//   data_sram_*           data request side (reads and writes)
//   ar*/r*                AXI3 read address / read data channels
//   aw*/w*/b*             AXI3 write address / write data / response
//   dbg_ar_state          read FSM state   (0 = idle, 1 = busy)
//   dbg_w_state           write FSM state  (0 = idle, 1 = send, 2 = resp)
//   dbg_rd_pend           {data_rd_pend, inst_rd_pend}
//
// Reads use AXI ID 0 for instructions and ID 1 for data, so at most two
// reads are outstanding and R beats are steered purely by rid. Only one
// data-side transaction (read or write) is in flight at a time, which
// rules out read-after-write hazards on the data port.

module sram_axi_arbiter (
  input  logic        clk,
  input  logic        reset,

  // instruction sram-like interface
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  // data sram-like interface
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  // AXI write address channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  // AXI write data channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  // AXI write response channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,

  // state visibility
  output logic        dbg_ar_state,
  output logic [1:0]  dbg_w_state,
  output logic [1:0]  dbg_rd_pend
);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  ar_state_t ar_state;
  w_state_t  w_state;

  logic inst_rd_pend;
  logic data_rd_pend;

  logic data_rd_cap;
  logic inst_rd_cap;
  logic wr_cap;
  logic r_to_inst;
  logic r_to_data;
  logic b_done;
  logic aw_finishing;
  logic w_finishing;

  // ------------------------------------------------------------------
  // Capture decisions (combinational, drive addr_ok in the same cycle)
  // ------------------------------------------------------------------

  // A data read waits for the write FSM to be idle and for any earlier
  // data read to return, so the data port never has two in flight.
  assign data_rd_cap = (ar_state == AR_IDLE) && data_sram_req && !data_sram_wr &&
                       !data_rd_pend && (w_state == W_IDLE);

  // Data side has fixed priority for the single AR slot.
  assign inst_rd_cap = (ar_state == AR_IDLE) && inst_sram_req && !inst_rd_pend &&
                       !data_rd_cap;

  assign wr_cap = (w_state == W_IDLE) && data_sram_req && data_sram_wr &&
                  !data_rd_pend && !data_rd_cap;

  assign inst_sram_addr_ok = inst_rd_cap;
  assign data_sram_addr_ok = data_rd_cap || wr_cap;

  // ------------------------------------------------------------------
  // Response steering
  // ------------------------------------------------------------------

  assign r_to_inst = rvalid && (rid == 4'd0);
  assign r_to_data = rvalid && (rid == 4'd1);
  assign b_done    = (w_state == W_RESP) && bvalid;

  assign inst_sram_data_ok = r_to_inst;
  assign data_sram_data_ok = r_to_data || b_done;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  // ------------------------------------------------------------------
  // Read address FSM
  // ------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      arid     <= 4'd0;
      araddr   <= 32'd0;
      arsize   <= 3'd0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (data_rd_cap) begin
            ar_state <= AR_BUSY;
            arvalid  <= 1'b1;
            arid     <= 4'd1;
            araddr   <= data_sram_addr;
            arsize   <= {1'b0, data_sram_size};
          end else if (inst_rd_cap) begin
            ar_state <= AR_BUSY;
            arvalid  <= 1'b1;
            arid     <= 4'd0;
            araddr   <= inst_sram_addr;
            arsize   <= {1'b0, inst_sram_size};
          end
        end
        AR_BUSY: begin
          if (arready) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
          end
        end
        default: begin
          ar_state <= AR_IDLE;
          arvalid  <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outstanding-read flags, one per AXI ID
  // ------------------------------------------------------------------

  // The flags are registered, so a flag cleared by data_ok still blocks a
  // new capture for that ID in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rd_pend <= 1'b0;
      data_rd_pend <= 1'b0;
    end else begin
      if (inst_rd_cap) begin
        inst_rd_pend <= 1'b1;
      end else if (r_to_inst) begin
        inst_rd_pend <= 1'b0;
      end

      if (data_rd_cap) begin
        data_rd_pend <= 1'b1;
      end else if (r_to_data) begin
        data_rd_pend <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Write FSM
  // ------------------------------------------------------------------

  // A channel counts as finished once its valid is low or is being
  // accepted this cycle; AW and W complete independently.
  assign aw_finishing = !awvalid || awready;
  assign w_finishing  = !wvalid  || wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_cap) begin
            w_state <= W_SEND;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= data_sram_addr;
            awsize  <= {1'b0, data_sram_size};
            wdata   <= data_sram_wdata;
            wstrb   <= data_sram_wstrb;
          end
        end
        W_SEND: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
          end
          if (aw_finishing && w_finishing) begin
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            w_state <= W_IDLE;
          end
        end
        default: begin
          w_state <= W_IDLE;
          awvalid <= 1'b0;
          wvalid  <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Constant AXI fields: single-beat INCR, normal access, fixed write ID
  // ------------------------------------------------------------------

  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = 4'd1;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = 4'd1;
  assign wlast   = 1'b1;

  assign rready  = 1'b1;
  assign bready  = 1'b1;

  assign dbg_ar_state = ar_state;
  assign dbg_w_state  = w_state;
  assign dbg_rd_pend  = {data_rd_pend, inst_rd_pend};

  // Inputs with no function here: the instruction port never writes,
  // responses are never errors, reads are single-beat and there is only
  // one write ID.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           rresp, rlast, bid, bresp};

endmodule

// File: doc/sram_axi_arbiter.md
# sram_axi_arbiter

Shares one AXI3 master port between the instruction-fetch and data-memory sram-like request interfaces of the LoongArch pipeline. Each side issues req/addr_ok/data_ok handshakes exactly as the IF and MEM stages drive them. The block serialises address issue onto AR/AW, steers R/B responses back by ID, and blocks data read/write overlap to avoid RAW hazards. It sits between the CPU core and the SoC AXI interconnect.

## Interface
- No parameters; address/data fixed at 32 bits, AXI IDs 4 bits.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_sram_req / wr / size[1:0] / wstrb[3:0] / addr[31:0] / wdata[31:0]  in  instruction request (wr, wstrb, wdata ignored; reads only)
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  read data returned this cycle
- inst_sram_rdata  out  32  returned instruction
- data_sram_req / wr / size[1:0] / wstrb[3:0] / addr[31:0] / wdata[31:0]  in  data request
- data_sram_addr_ok  out  1; data_sram_data_ok  out  1; data_sram_rdata  out  32
- arid[3:0], araddr[31:0], arsize[2:0], arvalid  out; arready  in
- arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0  out  constants
- rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in; rready  out (constant 1)
- awid=1, awaddr[31:0], awsize[2:0], awvalid  out; awready  in; awlen/awburst/awlock/awcache/awprot same constants as AR
- wid=1, wdata[31:0], wstrb[3:0], wlast=1, wvalid  out; wready  in
- bid[3:0], bresp[1:0], bvalid  in; bready  out (constant 1)

## Operation
- Read FSM: AR_IDLE, AR_BUSY. Write FSM: W_IDLE, W_SEND, W_RESP. Flags inst_rd_pend, data_rd_pend.
- Data read capture condition: AR_IDLE, data_sram_req, !wr, !data_rd_pend, W_IDLE.
- Inst read capture condition: AR_IDLE, inst_sram_req, !inst_rd_pend, data read not captured this cycle. Data has fixed priority over inst.
- On capture: addr_ok=1 to the winner (combinational, same cycle); araddr, arsize={1'b0,size}, arid (0=inst, 1=data) registered; FSM→AR_BUSY; winner's pend flag set.
- AR_BUSY: arvalid=1 held, payload stable, until arvalid&&arready; then →AR_IDLE.
- R return: rvalid with rid==0 → inst_sram_data_ok=1, inst_sram_rdata=rdata, clear inst_rd_pend. rid==1 → data side equivalent, clear data_rd_pend. rresp ignored.
- Write capture condition: W_IDLE, data_sram_req, wr, !data_rd_pend, data read not captured this cycle. Give data_sram_addr_ok; register addr, size, wstrb, wdata; →W_SEND.
- W_SEND: awvalid and wvalid both asserted; each deasserts independently after its own handshake. →W_RESP once both have completed (same or different cycles).
- W_RESP: bvalid → data_sram_data_ok=1, →W_IDLE.
- At most one data transaction (read or write) in flight. Data read data_ok and write data_ok never coincide.
- At most 2 reads outstanding (one per ID). Responses may return in either order.

## Timing
- Reset values: all valid outputs 0, all addr_ok/data_ok 0, rdata outputs = rdata passthrough, FSMs idle, pend flags 0, registered AXI payloads 0.
- Earliest arvalid: cycle after addr_ok. Earliest data_ok: same cycle as rvalid. Minimum read latency req→data_ok: 2 cycles, with arready=1 and rvalid the cycle after AR handshake.
- A pend flag cleared by data_ok blocks re-capture in that same cycle. The next request for that ID is accepted the following cycle at the earliest.
- AR capture only in AR_IDLE, so back-to-back reads issue at most every 2 cycles.
- Reset mid-transaction aborts all state with no draining. The interconnect is reset by the same signal.
- A request not accepted gets addr_ok=0. The requester holds req and its payload until addr_ok.

## Test plan
- Inst read 0x1c000000, arready=1, R returns rid=0 rdata=0x02800c0c one cycle later → addr_ok cycle 0, arvalid cycle 1, inst_data_ok with 0x02800c0c cycle 2.
- Inst and data read requests in the same cycle → data gets addr_ok and arid=1 first. Inst addr_ok comes at the next AR_IDLE cycle with arid=0.
- Both reads outstanding, R returns rid=1 before rid=0 → data_data_ok fires first, inst_data_ok second, each with its own rdata.
- Data write 0x1c0100f0, wstrb=4'b0011, awready delayed 3 cycles, wready=1 immediately → wvalid drops after 1 cycle, awvalid held 4 cycles, data_ok on bvalid.
- Data read requested during W_RESP → no addr_ok until the cycle after bvalid.
- Reset asserted while AR_BUSY → next cycle arvalid=0, pend flags 0, a fresh inst request is accepted immediately.
